// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and small op-classification helpers.
package mdu_pkg;

  localparam logic [1:0] MDU_OP_MULT  = 2'b00;
  localparam logic [1:0] MDU_OP_MULTU = 2'b01;
  localparam logic [1:0] MDU_OP_DIV   = 2'b10;
  localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MDU_MULT  = MDU_OP_MULT,
    MDU_MULTU = MDU_OP_MULTU,
    MDU_DIV   = MDU_OP_DIV,
    MDU_DIVU  = MDU_OP_DIVU
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_FINISH
  } mdu_state_t;

  function automatic logic isSignedOp(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic isDivOp(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> MDU handshake and HI/LO read-out bundle.
// Carries div_zero only when MDU_DIV_ZERO_DETECT_EN is defined.
interface mult_div_unit_if #(parameter int unsigned WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_DIV_ZERO_DETECT_EN
  logic             div_zero;

  modport master (output start, op, a, b, input busy, done, hi, lo, div_zero);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, div_zero);
`else
  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mdu_sign_adjust.sv
// Two's-complement conditional negate; with negate tied to the sign bit it
// yields the absolute value.
module mdu_sign_adjust #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    if (negate) result = ~value + 1'b1;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit (shift-add / restoring, one bit per cycle)
// owning HI/LO. Optional MDU_DIV_ZERO_DETECT_EN short-circuits divide by zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_t state, nextState;
  mdu_op_t    opIn, opReg;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   operandReg;
  logic [2*WIDTH-1:0] acc, accNext;
  logic               negResult, negRem, divByZero;
  logic [WIDTH-1:0]   hiReg, loReg;

  logic               signedIn, bZero, zeroShortcut;
  logic [WIDTH-1:0]   absA, absB;

  assign opIn     = mdu_op_t'(bus.op);
  assign signedIn = isSignedOp(opIn);
  assign bZero    = (bus.b == '0);

`ifdef MDU_DIV_ZERO_DETECT_EN
  assign zeroShortcut = isDivOp(opIn) && bZero;
`else
  assign zeroShortcut = 1'b0;
`endif

  mdu_sign_adjust #(.WIDTH(WIDTH)) absAInst (
    .value(bus.a), .negate(signedIn & bus.a[WIDTH-1]), .result(absA)
  );

  mdu_sign_adjust #(.WIDTH(WIDTH)) absBInst (
    .value(bus.b), .negate(signedIn & bus.b[WIDTH-1]), .result(absB)
  );

  // One iteration of either algorithm; operandReg is the multiplicand or the divisor.
  logic [WIDTH:0]     mulSum;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trial;
  logic               fits;
  logic [2*WIDTH-1:0] mulNext, divNext;

  always_comb begin
    addend  = acc[0] ? operandReg : '0;
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mulNext = {mulSum, acc[WIDTH-1:1]};

    shifted = {acc, 1'b0};
    fits    = shifted[2*WIDTH:WIDTH] >= {1'b0, operandReg};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, operandReg};
    divNext = fits ? {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1}
                   : shifted[2*WIDTH-1:0];

    accNext = isDivOp(opReg) ? divNext : mulNext;
  end

  // Sign fix-up applied to the final iteration's result as it is written to HI/LO.
  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH-1:0]   quotFixed, remFixed;
  logic [WIDTH-1:0]   finalHi, finalLo;

  mdu_sign_adjust #(.WIDTH(2*WIDTH)) prodFixInst (
    .value(accNext), .negate(negResult), .result(prodFixed)
  );

  // A zero divisor leaves the all-ones quotient unnegated.
  mdu_sign_adjust #(.WIDTH(WIDTH)) quotFixInst (
    .value(accNext[WIDTH-1:0]), .negate(negResult & ~divByZero), .result(quotFixed)
  );

  mdu_sign_adjust #(.WIDTH(WIDTH)) remFixInst (
    .value(accNext[2*WIDTH-1:WIDTH]), .negate(negRem), .result(remFixed)
  );

  always_comb begin
    finalHi = prodFixed[2*WIDTH-1:WIDTH];
    finalLo = prodFixed[WIDTH-1:0];
    if (isDivOp(opReg)) begin
      finalHi = remFixed;
      finalLo = quotFixed;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MDU_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      MDU_IDLE:   if (bus.start) nextState = zeroShortcut ? MDU_FINISH : MDU_CALC;
      MDU_CALC:   if (count == LAST) nextState = MDU_FINISH;
      MDU_FINISH: nextState = MDU_IDLE;
      default:    nextState = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      acc        <= '0;
      operandReg <= '0;
      opReg      <= MDU_MULT;
      negResult  <= 1'b0;
      negRem     <= 1'b0;
      divByZero  <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else begin
      unique case (state)
        MDU_IDLE: begin
          if (bus.start) begin
            opReg     <= opIn;
            count     <= '0;
            negResult <= signedIn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negRem    <= signedIn & bus.a[WIDTH-1];
            divByZero <= bZero;
            if (isDivOp(opIn)) begin
              acc        <= {{WIDTH{1'b0}}, absA};
              operandReg <= absB;
            end else begin
              acc        <= {{WIDTH{1'b0}}, absB};
              operandReg <= absA;
            end
          end
        end
        MDU_CALC: begin
          acc   <= accNext;
          count <= count + 1'b1;
          if (count == LAST) begin
            hiReg <= finalHi;
            loReg <= finalLo;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MDU_DIV_ZERO_DETECT_EN
  logic zeroFlag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  zeroFlag <= 1'b0;
    else if (state == MDU_IDLE) zeroFlag <= bus.start & zeroShortcut;
  end

  assign bus.div_zero = (state == MDU_FINISH) & zeroFlag;
`endif

  assign bus.busy = (state != MDU_IDLE);
  assign bus.done = (state == MDU_FINISH);
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule
